// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit, item select, per-item stock.
// Define CHANGE_RETURN_EN to pay residual credit and cancel refunds as nickels.
module vending_machine_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 6,
    parameter int STOCK_INIT = 7,
    parameter int STOCK_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inN,
    input  logic                         inD,
    input  logic                         inQ,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel,
    input  logic                         cancel,
    input  logic                         restock,
    output logic                         out,
    output logic [$clog2(NUM_ITEMS)-1:0] out_item,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         chg_nickel,
    output logic                         coin_rej,
    output logic                         sel_err,
    output logic [NUM_ITEMS-1:0]         empty,
    output logic                         busy
);
    localparam int SEL_W = $clog2(NUM_ITEMS);
    localparam logic [CREDIT_W:0]   CMAX    = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);
    localparam logic [SEL_W:0]      NUM_C   = (SEL_W+1)'(NUM_ITEMS);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t               state, state_n;
    logic [CREDIT_W-1:0]  credit_n;
    logic [SEL_W-1:0]     out_item_n;
    logic                 out_n, coin_rej_n, sel_err_n;
    logic [STOCK_W-1:0]   stock [NUM_ITEMS];

    logic [3:0]           sum;
    logic                 coin_any, sel_ok, open, accept, do_cancel;
    logic [CREDIT_W:0]    base, total;

    assign sum      = {3'b000, inN} + {2'b00, inD, 1'b0} + (inQ ? 4'd5 : 4'd0);
    assign coin_any = inN | inD | inQ;
    assign sel_ok   = {1'b0, sel} < NUM_C;
    assign open     = (state == IDLE) || (state == CREDIT);
    assign busy     = (state == VEND) || (state == CHANGE);

`ifdef CHANGE_RETURN_EN
    assign do_cancel  = (state == CREDIT) && cancel;
    assign chg_nickel = (state == CHANGE);
`else
    assign do_cancel  = 1'b0;
    assign chg_nickel = 1'b0;
`endif

    // cancel wins over a same-cycle selection
    assign accept = open && !do_cancel && sel_valid && sel_ok &&
                    (stock[sel] != '0) && (credit >= PRICE_C);

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++)
            empty[i] = (stock[i] == '0);
    end

    always_comb begin
        state_n    = state;
        credit_n   = credit;
        out_n      = 1'b0;
        out_item_n = out_item;
        coin_rej_n = 1'b0;
        sel_err_n  = 1'b0;
        base       = {1'b0, credit};
        total      = base;
        unique case (state)
            IDLE, CREDIT: begin
                if (do_cancel) begin
                    state_n    = CHANGE;
                    coin_rej_n = coin_any;
                end else begin
                    if (accept)
                        base = {1'b0, credit - PRICE_C};
                    sel_err_n = sel_valid && !accept;
                    total     = base + (CREDIT_W+1)'(sum);
                    // an overflowing coin sum is rejected as a whole
                    if (total > CMAX) begin
                        coin_rej_n = 1'b1;
                        credit_n   = base[CREDIT_W-1:0];
                    end else begin
                        credit_n = total[CREDIT_W-1:0];
                    end
                    if (accept) begin
                        state_n    = VEND;
                        out_n      = 1'b1;
                        out_item_n = sel;
                    end else begin
                        state_n = (credit_n != '0) ? CREDIT : IDLE;
                    end
                end
            end
            VEND: begin
                coin_rej_n = coin_any;
                sel_err_n  = sel_valid;
                if (credit == '0)
                    state_n = IDLE;
                else
`ifdef CHANGE_RETURN_EN
                    state_n = CHANGE;
`else
                    state_n = CREDIT;
`endif
            end
`ifdef CHANGE_RETURN_EN
            CHANGE: begin
                coin_rej_n = coin_any;
                sel_err_n  = sel_valid;
                credit_n   = credit - 1'b1;
                if (credit <= CREDIT_W'(1))
                    state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            credit   <= '0;
            out      <= 1'b0;
            out_item <= '0;
            coin_rej <= 1'b0;
            sel_err  <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= STOCK_C;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            out      <= out_n;
            out_item <= out_item_n;
            coin_rej <= coin_rej_n;
            sel_err  <= sel_err_n;
            if (open && restock) begin
                for (int i = 0; i < NUM_ITEMS; i++)
                    stock[i] <= STOCK_C;
            end else if (state == VEND) begin
                stock[out_item] <= stock[out_item] - 1'b1;
            end
        end
    end
endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised multi-item vending controller: accepts nickel/dime/quarter coin pulses into a credit accumulator, vends one of NUM_ITEMS products on a select request when credit and stock allow, tracks per-item stock, and optionally returns change as nickel pulses. It is the next generation of the single-product nickel/dime vending FSM and drops into the same front-panel/coin-mechanism interface, adding a quarter input, item selection, stock and change.

## Interface
- NUM_ITEMS, 4: number of products (≥2)
- PRICE, 3: item price in nickel units (3 = 15 cents), 1..2^CREDIT_W-1
- CREDIT_W, 6: credit register width; max credit CMAX = 2^CREDIT_W-1 nickels
- STOCK_INIT, 7: per-item stock at reset/restock
- STOCK_W, 3: stock counter width; STOCK_INIT < 2^STOCK_W
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- inN / inD / inQ  in  1 each  coin pulses, one cycle each: 1 / 2 / 5 nickel units
- sel_valid  in  1  selection request, one cycle
- sel  in  $clog2(NUM_ITEMS)  item index, qualified by sel_valid
- cancel  in  1  refund request
- restock  in  1  reload all stock counters
- out  out  1  vend pulse, one cycle
- out_item  out  $clog2(NUM_ITEMS)  item vended; valid with out, holds last value otherwise
- credit  out  CREDIT_W  current credit, nickel units
- chg_nickel  out  1  one nickel of change per asserted cycle
- coin_rej  out  1  coin rejected, one-cycle pulse
- sel_err  out  1  selection refused, one-cycle pulse
- empty  out  NUM_ITEMS  bit i high when stock[i]==0
- busy  out  1  high in VEND or CHANGE

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Coins (IDLE/CREDIT): coins asserted together are summed; if credit+sum ≤ CMAX, the sum is added; otherwise the whole sum is rejected (coin_rej), credit unchanged. In VEND/CHANGE all coins are rejected.
- Selection (IDLE/CREDIT), evaluated on credit before that cycle's coins: accepted iff sel<NUM_ITEMS, stock[sel]>0 and credit≥PRICE → VEND. Otherwise sel_err; state and credit unchanged. A coin in the same cycle is still added normally. If the selection is accepted, credit = credit−PRICE+coin sum (saturation check applies to that result).
- VEND (one cycle): out=1, out_item=sel, stock[sel]−1. Next state is CHANGE if the remaining credit is >0 and CHANGE_RETURN_EN is defined; otherwise CREDIT if credit>0, else IDLE.
- CHANGE: chg_nickel=1 every cycle, credit decrements by 1 per cycle; when it reaches 0 → IDLE. sel_valid gives sel_err; cancel is ignored.
- cancel (CREDIT, CHANGE_RETURN_EN defined): → CHANGE, which refunds all credit. cancel in IDLE has no effect. cancel takes priority over sel_valid in the same cycle; coins in that cycle are rejected.
- restock is honoured only in IDLE or CREDIT; it reloads every stock counter to STOCK_INIT. Ignored in VEND/CHANGE.

## Timing
- All outputs are registered except chg_nickel, busy and empty, which decode registered state.
- Reset (rst==0 at an edge): state IDLE, credit 0, stock = STOCK_INIT, out/out_item/coin_rej/sel_err 0, chg_nickel 0, busy 0, empty all-0. Reset overrides every input and is allowed mid-VEND or mid-CHANGE; the outstanding credit is forfeited.
- Coin at edge t → credit updated (or coin_rej=1) at t+1.
- sel_valid at edge t → out=1 (or sel_err=1) during t+1 → first chg_nickel during t+2.
- Change of k nickels: chg_nickel high for exactly k consecutive cycles; credit reads 0 and state IDLE in the following cycle.
- empty[i] updates the cycle after the vend that drains item i.

## Configuration
- CHANGE_RETURN_EN defined: CHANGE state present. Residual credit after a vend and cancel refunds are paid out as chg_nickel pulses.
- Not defined: no CHANGE state, chg_nickel tied 0, cancel ignored. After a vend the remaining credit is retained (CREDIT) for further purchases.

## Test plan
- Reset, inD then inN (credit 3), sel=2 → out=1 for 1 cycle, out_item=2, credit 0, empty[2]=0 with stock[2]=6, no chg_nickel, state IDLE.
- inQ (credit 5), sel=0 → vend, then chg_nickel high for 2 cycles and credit 5→2→1→0. Without the macro: credit stays 2 and chg_nickel is never asserted.
- inN (credit 1), sel=1 → sel_err 1 cycle, credit 1, no out. Then cancel → 1 chg_nickel cycle, then IDLE.
- 7 vends of item 3 → empty[3]=1. 8th sel=3 with credit 3 → sel_err, credit 3. restock → empty[3]=0.
- Credit 60, inQ → coin_rej, credit 60. Then inD → credit 62. inN+inD in the same cycle → coin_rej, credit 62.
- Credit 5, vend, rst=0 during the first chg_nickel cycle → next cycle credit 0, state IDLE, chg_nickel 0, stock = STOCK_INIT.
